sudoku_grid_filler: RTL and testbench
=====================================

Name: sudoku_grid_filler

Overview:
- Autonomous Sudoku grid generator for the "grid" role in the design.
- On `start`, it fills an L×L grid (L = ORDER²) so every row, column and ORDER×ORDER block holds each value 1..L exactly once.
- It uses a one-cell-per-cycle sequential backtracking search, then reports `done`/`success`.
- The filled grid is held internally and read hierarchically by downstream logic and the bench.

Parameters:
- ORDER, 2, block side length; L = ORDER², cell count C = L². Supported range 2..4.
- LFSR_SEED, 16'hACE1, non-zero seed of the 16-bit Galois LFSR (x^16+x^14+x^13+x^11). Used only with GRID_SHUFFLE_EN.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins or restarts a fill.
- done  output  1  high while a finished result is held.
- success  output  1  valid while `done`=1: 1 = grid complete and legal, 0 = search exhausted.

Behaviour:
- Storage: array `cells[0:C-1]`, each $clog2(L+1) bits, 0 = empty. Cell index i maps to row i/L, col i%L.
- Storage: per-cell tried mask `tried[i]`, L bits.
- Storage: cursor `idx` of $clog2(C) bits; FSM states IDLE, SEARCH, FINISH.
- Reset (reset=0, asynchronous): state=IDLE, all cells=0, all tried=0, idx=0, done=0, success=0, LFSR=LFSR_SEED.
- IDLE: on start=1, go to SEARCH. Clear every cell and tried mask, set idx=0 and done=0, all on that edge.
- SEARCH, combinational each cycle: used = OR of one-hot values of `cells` in row(idx), col(idx) and block(idx), excluding idx itself. Cells after idx are always empty.
- SEARCH, combinational: avail = ~used & ~tried[idx]. cand = lowest set bit of avail, in ascending value order (rotated order with the macro).
- SEARCH, when avail≠0: cells[idx]=cand value and tried[idx] |= cand.
  - If idx==C-1: go to FINISH with done=1, success=1.
  - Otherwise idx++.
- SEARCH, when avail==0: cells[idx]=0 and tried[idx]=0.
  - If idx==0: go to FINISH with done=1, success=0.
  - Otherwise idx--. The previous cell's current value is already marked tried.
- Latency: exactly one placement or backtrack step per cycle. With no backtracking, done rises on the C-th rising edge after the edge that sampled start.
- FINISH: done and success hold steady and cells are frozen. start=1 restarts exactly as from IDLE, with done dropping on that edge.
- start during SEARCH is ignored; no restart and no effect.
- Reset mid-search aborts immediately to the reset values. A later start performs a full fresh fill.
- The LFSR steps every cycle while in SEARCH.
- Invariant: at every cycle, filled cells 0..idx-1 satisfy all row, column and block constraints.

Optional Feature:
- Macro: GRID_SHUFFLE_EN.
- Defined: on the cycle a cell is first entered with tried[idx]==0, rot[idx] = LFSR mod L is latched (extra per-cell register).
  - Candidates are scanned in order rot, rot+1, … mod L; the value chosen is the first available in that order.
  - Different seeds give different valid grids. Results are reproducible for a given seed.
- Undefined: no LFSR or rot registers; strictly ascending scan; output is the lexicographically smallest valid grid, fully deterministic.

Test Plan:
- Reset low 1 cycle, then high; start low → done=0, success=0, all cells 0, held indefinitely.
- Macro off, ORDER=2, one start pulse → done=1 and success=1 exactly 16 edges after start is sampled. Rows must read 1 2 3 4 / 3 4 1 2 / 2 1 4 3 / 4 3 2 1.
- After done, hold start low 20 cycles → done, success and cells unchanged. Then pulse start → done drops next edge and the same grid reappears after 16 edges.
- Pulse start again 5 cycles into SEARCH → ignored; completion timing is identical to a single start.
- Assert reset at SEARCH cycle 8 → outputs and cells zero immediately (asynchronously). A new start yields the full correct grid.
- Macro on, ORDER=3, two different LFSR_SEED values → both end with done=1, success=1. The checker verifies every row, column and 3×3 block is a permutation of 1..9, and the two grids differ.

Source files
------------

// File: rtl/sudoku_grid_filler.sv
// Sudoku grid filler: one placement or backtrack step per cycle over an L x L grid.
// Optional macro GRID_SHUFFLE_EN enables LFSR-rotated candidate order per cell.
module sudoku_grid_filler #(
    parameter int          ORDER     = 2,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    output logic done,
    output logic success
);

    localparam int L  = ORDER * ORDER;
    localparam int C  = L * L;
    localparam int VW = $clog2(L + 1);
    localparam int IW = $clog2(C);
    localparam int PW = $clog2(L);

    if (ORDER < 2 || ORDER > 4 || LFSR_SEED == 16'h0) begin : g_bad_cfg
        $error("sudoku_grid_filler: ORDER must be 2..4 and LFSR_SEED non-zero");
    end

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        FINISH
    } state_t;

    state_t r_state;
    state_t w_state_n;

    logic [VW-1:0] cells [0:C-1];
    logic [L-1:0]  tried [0:C-1];
    logic [IW-1:0] idx;
    logic          r_done;
    logic          r_success;

    logic [L-1:0]  w_used;
    logic [L-1:0]  w_avail;
    logic [L-1:0]  w_cand_oh;
    logic [VW-1:0] w_cand_val;
    logic [PW-1:0] w_pos;
    logic          w_go;
    logic          w_last;
    logic          w_first;
    logic          w_restart;
    int            w_row;
    int            w_col;
    int            w_blk;
    int            w_base;
    int            w_sum;

`ifdef GRID_SHUFFLE_EN
    logic [15:0]   r_lfsr;
    logic [PW-1:0] r_rot [0:C-1];
    logic [PW-1:0] w_rot_new;

    assign w_rot_new = PW'(r_lfsr % 16'(L));
`endif

    assign w_go      = (w_avail != '0);
    assign w_last    = (idx == IW'(C - 1));
    assign w_first   = (idx == '0);
    assign w_restart = start && (r_state != SEARCH);
    assign done      = r_done;
    assign success   = r_success;

    // Values already present among the peers of the cursor cell.
    always_comb begin
        w_used = '0;
        w_row  = int'(idx) / L;
        w_col  = int'(idx) % L;
        w_blk  = (w_row / ORDER) * ORDER + w_col / ORDER;
        for (int j = 0; j < C; j++) begin
            if (j != int'(idx) &&
                (j / L == w_row || j % L == w_col ||
                 ((j / L) / ORDER) * ORDER + (j % L) / ORDER == w_blk)) begin
                for (int k = 0; k < L; k++) begin
                    if (cells[j] == VW'(k + 1)) begin
                        w_used[k] = 1'b1;
                    end
                end
            end
        end
    end

    // First available value scanning upward from the base position, with wrap.
    always_comb begin
        w_avail = ~w_used & ~tried[idx];
`ifdef GRID_SHUFFLE_EN
        w_base = (tried[idx] == '0) ? int'(w_rot_new) : int'(r_rot[idx]);
`else
        w_base = 0;
`endif
        w_cand_oh  = '0;
        w_cand_val = '0;
        w_pos      = '0;
        w_sum      = 0;
        for (int k = 0; k < L; k++) begin
            w_sum = w_base + k;
            if (w_sum >= L) begin
                w_sum = w_sum - L;
            end
            w_pos = PW'(w_sum);
            if (w_cand_oh == '0 && w_avail[w_pos]) begin
                w_cand_oh[w_pos] = 1'b1;
                w_cand_val       = VW'(w_sum + 1);
            end
        end
    end

    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_n = SEARCH;
                end
            end
            SEARCH: begin
                if (w_go && w_last) begin
                    w_state_n = FINISH;
                end else if (!w_go && w_first) begin
                    w_state_n = FINISH;
                end
            end
            FINISH: begin
                if (start) begin
                    w_state_n = SEARCH;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx       <= '0;
            r_done    <= 1'b0;
            r_success <= 1'b0;
            for (int i = 0; i < C; i++) begin
                cells[i] <= '0;
                tried[i] <= '0;
            end
        end else if (w_restart) begin
            idx       <= '0;
            r_done    <= 1'b0;
            r_success <= 1'b0;
            for (int i = 0; i < C; i++) begin
                cells[i] <= '0;
                tried[i] <= '0;
            end
        end else if (r_state == SEARCH) begin
            if (w_go) begin
                cells[idx] <= w_cand_val;
                tried[idx] <= tried[idx] | w_cand_oh;
                if (w_last) begin
                    r_done    <= 1'b1;
                    r_success <= 1'b1;
                end else begin
                    idx <= idx + IW'(1);
                end
            end else begin
                // Going back: the earlier cell's value stays in its tried mask.
                cells[idx] <= '0;
                tried[idx] <= '0;
                if (w_first) begin
                    r_done    <= 1'b1;
                    r_success <= 1'b0;
                end else begin
                    idx <= idx - IW'(1);
                end
            end
        end
    end

`ifdef GRID_SHUFFLE_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_lfsr <= LFSR_SEED;
            for (int i = 0; i < C; i++) begin
                r_rot[i] <= '0;
            end
        end else if (r_state == SEARCH) begin
            r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
            if (tried[idx] == '0) begin
                r_rot[idx] <= w_rot_new;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sudoku_grid_filler.sv
// Bench for sudoku_grid_filler: scenario table, random start/reset timing,
// brute-force reference grid and structural legality checks.
module tb_sudoku_grid_filler;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset, start, done, success;
    logic reset3, start3, done3, success3;

    int n_cmp = 0;
    int n_bad = 0;
    int ref_g [0:80];
    int spec_g [0:15] = '{1, 2, 3, 4, 3, 4, 1, 2, 2, 1, 4, 3, 4, 3, 2, 1};
    bit prev_done = 1'b0;

    typedef struct {
        int gap;
        int extra;
        int rst;
        int exp_lat;
        int exp_succ;
    } vec_t;

    vec_t tbl [0:4];

    sudoku_grid_filler #(.ORDER(2)) u_dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .done   (done),
        .success(success)
    );

    sudoku_grid_filler #(.ORDER(3), .LFSR_SEED(16'hACE1)) u_d3 (
        .clock  (clock),
        .reset  (reset3),
        .start  (start3),
        .done   (done3),
        .success(success3)
    );

`ifdef GRID_SHUFFLE_EN
    logic done3b, success3b;
    sudoku_grid_filler #(.ORDER(3), .LFSR_SEED(16'h1D0F)) u_d3b (
        .clock  (clock),
        .reset  (reset3),
        .start  (start3),
        .done   (done3b),
        .success(success3b)
    );
`endif

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Count rows, columns and blocks that are not a permutation of 1..L.
    function automatic int bad_units(input int g [0:80], input int ord);
        int l, bad, r, c, v;
        logic [15:0] m;
        l   = ord * ord;
        bad = 0;
        for (int t = 0; t < 3; t++) begin
            for (int u = 0; u < l; u++) begin
                m = '0;
                for (int k = 0; k < l; k++) begin
                    if (t == 0) begin
                        r = u; c = k;
                    end else if (t == 1) begin
                        r = k; c = u;
                    end else begin
                        r = (u / ord) * ord + k / ord;
                        c = (u % ord) * ord + k % ord;
                    end
                    v = g[r * l + c];
                    if (v >= 1 && v <= l) m[v - 1] = 1'b1;
                end
                if (m != 16'((1 << l) - 1)) bad++;
            end
        end
        return bad;
    endfunction

    function automatic int diff_ref();
        int d = 0;
        for (int i = 0; i < 16; i++) begin
            if (int'(u_dut.cells[i]) != ref_g[i]) d++;
        end
        return d;
    endfunction

    function automatic int nonzero2();
        int d = 0;
        for (int i = 0; i < 16; i++) begin
            if (u_dut.cells[i] != '0) d++;
        end
        return d;
    endfunction

    // Lexicographically smallest legal 4x4 grid: rows chosen from the
    // 24 permutations in ascending order, first legal combination wins.
    task automatic build_ref();
        int perms [0:23][0:3];
        int np = 0;
        int g [0:80];
        bit found = 1'b0;
        for (int a = 1; a <= 4; a++)
            for (int b = 1; b <= 4; b++)
                for (int c = 1; c <= 4; c++)
                    for (int d = 1; d <= 4; d++)
                        if (a != b && a != c && a != d && b != c && b != d && c != d) begin
                            perms[np][0] = a; perms[np][1] = b;
                            perms[np][2] = c; perms[np][3] = d;
                            np++;
                        end
        for (int i = 0; i < 81; i++) g[i] = 0;
        for (int i0 = 0; i0 < 24 && !found; i0++)
            for (int i1 = 0; i1 < 24 && !found; i1++)
                for (int i2 = 0; i2 < 24 && !found; i2++)
                    for (int i3 = 0; i3 < 24 && !found; i3++) begin
                        for (int k = 0; k < 4; k++) begin
                            g[k]      = perms[i0][k];
                            g[4 + k]  = perms[i1][k];
                            g[8 + k]  = perms[i2][k];
                            g[12 + k] = perms[i3][k];
                        end
                        if (bad_units(g, 2) == 0) begin
                            found = 1'b1;
                            ref_g = g;
                        end
                    end
    endtask

    task automatic run_fill(input int gap, input int extra, input int rst,
                            input int exp_lat, input int exp_succ, input string tag);
        bit stable;
        int lat;
        bit aborted;
        stable  = 1'b1;
        lat     = 0;
        aborted = 1'b0;
        for (int i = 0; i < gap; i++) begin
            @(posedge clock); #1;
            if (prev_done) begin
                if (done !== 1'b1 || success !== 1'b1 || diff_ref() != 0) stable = 1'b0;
            end else begin
                if (done !== 1'b0 || nonzero2() != 0) stable = 1'b0;
            end
        end
        if (gap > 0) chk({tag, "_hold"}, int'(stable), 1);
        @(negedge clock);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        chk({tag, "_done_drop"}, int'(done), 0);
        for (int n = 1; n <= 40 && lat == 0 && !aborted; n++) begin
            @(posedge clock); #1;
            start = (n == extra);
            if (n == rst) begin
                reset = 1'b0;
                #1;
                chk({tag, "_rst_out"}, int'({done, success}), 0);
                chk({tag, "_rst_cells"}, nonzero2(), 0);
                chk({tag, "_rst_idx"}, int'(u_dut.idx), 0);
                @(negedge clock);
                reset   = 1'b1;
                aborted = 1'b1;
            end else if (done === 1'b1) begin
                lat = n;
            end
        end
        start = 1'b0;
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_success"}, int'(success), exp_succ);
        if (exp_lat > 0) begin
            chk({tag, "_grid"}, diff_ref(), 0);
        end else begin
            chk({tag, "_grid_empty"}, nonzero2(), 0);
        end
        prev_done = (lat > 0);
    endtask

    initial begin
        int g3 [0:80];
        int bad_seq;
        bit fin3;
        reset  = 1'b0;
        start  = 1'b0;
        reset3 = 1'b0;
        start3 = 1'b0;
        build_ref();
        for (int i = 0; i < 81; i++) g3[i] = 0;

        tbl[0] = '{gap: 0,  extra: -1, rst: -1, exp_lat: 16, exp_succ: 1};
        tbl[1] = '{gap: 20, extra: -1, rst: -1, exp_lat: 16, exp_succ: 1};
        tbl[2] = '{gap: 3,  extra: 5,  rst: -1, exp_lat: 16, exp_succ: 1};
        tbl[3] = '{gap: 2,  extra: -1, rst: 8,  exp_lat: 0,  exp_succ: 0};
        tbl[4] = '{gap: 4,  extra: 1,  rst: -1, exp_lat: 16, exp_succ: 1};

        @(posedge clock); #1;
        @(negedge clock);
        reset  = 1'b1;
        reset3 = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        chk("reset_done", int'(done), 0);
        chk("reset_success", int'(success), 0);
        chk("reset_cells", nonzero2(), 0);
        chk("reset_idx", int'(u_dut.idx), 0);

        for (int i = 0; i < 5; i++) begin
            run_fill(tbl[i].gap, tbl[i].extra, tbl[i].rst,
                     tbl[i].exp_lat, tbl[i].exp_succ, $sformatf("vec%0d", i));
            if (i == 0) begin
                bad_seq = 0;
                for (int k = 0; k < 16; k++) begin
                    if (int'(u_dut.cells[k]) != spec_g[k]) bad_seq++;
                end
                chk("known_grid", bad_seq, 0);
            end
        end

        for (int i = 0; i < 10; i++) begin
            int gap, extra, rst;
            gap   = int'($urandom_range(0, 25));
            extra = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 14)) : -1;
            rst   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : -1;
            run_fill(gap, extra, rst, (rst >= 0) ? 0 : 16, (rst >= 0) ? 0 : 1,
                     $sformatf("rnd%0d", i));
        end

        @(negedge clock);
        start3 = 1'b1;
        @(posedge clock); #1;
        start3 = 1'b0;
        fin3 = 1'b0;
        for (int n = 0; n < 40000 && !fin3; n++) begin
            @(posedge clock); #1;
`ifdef GRID_SHUFFLE_EN
            fin3 = (done3 === 1'b1) && (done3b === 1'b1);
`else
            fin3 = (done3 === 1'b1);
`endif
        end
        chk("o3_done", int'(done3), 1);
        chk("o3_success", int'(success3), 1);
        for (int i = 0; i < 81; i++) g3[i] = int'(u_d3.cells[i]);
        chk("o3_legal", bad_units(g3, 3), 0);
`ifdef GRID_SHUFFLE_EN
        begin
            int g3b [0:80];
            int nd;
            nd = 0;
            for (int i = 0; i < 81; i++) begin
                g3b[i] = int'(u_d3b.cells[i]);
                if (g3b[i] != g3[i]) nd++;
            end
            chk("o3b_success", int'(success3b), 1);
            chk("o3b_legal", bad_units(g3b, 3), 0);
            chk("o3_seeds_differ", int'(nd > 0), 1);
        end
`else
        bad_seq = 0;
        for (int c = 0; c < 9; c++) begin
            if (g3[c] != c + 1) bad_seq++;
        end
        chk("o3_row0_ascending", bad_seq, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
